// File: rtl/a2_mem_pkg.sv
// Shared definitions for the video/processor RAM slot sequencer:
// slot FSM states, slot-owner encoding and RAM address width.
package a2_mem_pkg;

  localparam int RAM_AW = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VID_ACT = 3'd1,
    ST_VID_CAP = 3'd2,
    ST_PRC_ACT = 3'd3,
    ST_PRC_CAP = 3'd4
  } slot_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/strobe_edge_detect.sv
// Registers one timing-generator strobe and flags its rising and falling
// edges relative to the previous CLK_14M cycle.
module strobe_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic rise_o,
  output logic fall_o
);

  logic strobe_q;

  // The reset value matches the strobe's idle level so no edge is seen
  // on the first cycle after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      strobe_q <= RESET_VAL;
    end else begin
      strobe_q <= strobe_i;
    end
  end

  assign rise_o = ~strobe_q & strobe_i;
  assign fall_o = strobe_q & ~strobe_i;

endmodule

// File: rtl/memory_slot_arbiter.sv
// Sequences the shared single-port RAM between video fetch (PHI0 low) and
// processor slots (PHI0 high) owned by either the CPU or a DMA master.
module memory_slot_arbiter
  import a2_mem_pkg::*;
#(
  parameter bit DMA_ENABLE = 1'b1
) (
  input  logic              CLK_14M,
  input  logic              RESET_N,
  input  logic              PHI0,
  input  logic              RAS_N,
  input  logic              CAS_N,
  input  logic [RAM_AW-1:0] VIDEO_ADDRESS,
  input  logic [RAM_AW-1:0] CPU_ADDR,
  input  logic              CPU_WE,
  input  logic [7:0]        CPU_DIN,
  input  logic              DMA_REQ,
  input  logic [RAM_AW-1:0] DMA_ADDR,
  input  logic              DMA_WE,
  input  logic [7:0]        DMA_DIN,
  output logic [RAM_AW-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [7:0]        RAM_DOUT,
  input  logic [7:0]        RAM_DIN,
  output logic [7:0]        VIDEO_DATA,
  output logic              VID_STB,
  output logic [7:0]        CPU_DOUT,
  output logic              CPU_RDY,
  output logic              DMA_GNT,
  output logic              DMA_ACK,
  output logic [7:0]        DMA_DOUT
);

  logic phi0Rise;
  logic phi0Fall;
  logic rasFall;
  logic casFall;
  logic rasRise_unused;
  logic casRise_unused;

  strobe_edge_detect #(.RESET_VAL(1'b0)) uPhi0Edge (
    .clk_i    (CLK_14M),
    .rst_ni   (RESET_N),
    .strobe_i (PHI0),
    .rise_o   (phi0Rise),
    .fall_o   (phi0Fall)
  );

  strobe_edge_detect #(.RESET_VAL(1'b1)) uRasEdge (
    .clk_i    (CLK_14M),
    .rst_ni   (RESET_N),
    .strobe_i (RAS_N),
    .rise_o   (rasRise_unused),
    .fall_o   (rasFall)
  );

  strobe_edge_detect #(.RESET_VAL(1'b1)) uCasEdge (
    .clk_i    (CLK_14M),
    .rst_ni   (RESET_N),
    .strobe_i (CAS_N),
    .rise_o   (casRise_unused),
    .fall_o   (casFall)
  );

  slot_state_e       state_q;
  logic              owner_q;
  logic              slotWe_q;
  logic [RAM_AW-1:0] ramAddr_q;
  logic              ramWe_q;
  logic [7:0]        ramDout_q;
  logic [7:0]        videoData_q;
  logic              vidStb_q;
  logic [7:0]        cpuDout_q;
  logic [7:0]        dmaDout_q;
  logic              dmaGnt_q;
  logic              dmaAck_q;

  logic              ownerNow;
  logic [RAM_AW-1:0] ownerAddr;
  logic [7:0]        ownerDin;
  logic              ownerWe;

  assign ownerNow  = dmaGnt_q ? OWN_DMA : OWN_CPU;
  assign ownerAddr = (ownerNow == OWN_DMA) ? DMA_ADDR : CPU_ADDR;
  assign ownerDin  = (ownerNow == OWN_DMA) ? DMA_DIN  : CPU_DIN;
  assign ownerWe   = (ownerNow == OWN_DMA) ? DMA_WE   : CPU_WE;

  // Owner, address, data and write intent are frozen at RAS fall so that
  // later changes by the master cannot disturb a slot already in progress.
  always_ff @(posedge CLK_14M) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      slotWe_q    <= 1'b0;
      ramAddr_q   <= '0;
      ramWe_q     <= 1'b0;
      ramDout_q   <= '0;
      videoData_q <= '0;
      vidStb_q    <= 1'b0;
      cpuDout_q   <= '0;
      dmaDout_q   <= '0;
      dmaGnt_q    <= 1'b0;
      dmaAck_q    <= 1'b0;
    end else begin
      ramWe_q  <= 1'b0;
      vidStb_q <= 1'b0;
      dmaAck_q <= 1'b0;

      if (phi0Rise) begin
        dmaGnt_q <= DMA_REQ & DMA_ENABLE;
      end

      case (state_q)
        ST_IDLE: begin
          if (rasFall) begin
            if (!PHI0) begin
              state_q   <= ST_VID_ACT;
              ramAddr_q <= VIDEO_ADDRESS;
            end else begin
              state_q   <= ST_PRC_ACT;
              ramAddr_q <= ownerAddr;
              ramDout_q <= ownerDin;
              owner_q   <= ownerNow;
              slotWe_q  <= ownerWe;
            end
          end
        end
        ST_VID_ACT: begin
          if (phi0Rise || phi0Fall) begin
            state_q <= ST_IDLE;
          end else if (casFall) begin
            state_q <= ST_VID_CAP;
          end
        end
        ST_PRC_ACT: begin
          if (phi0Rise || phi0Fall) begin
            state_q <= ST_IDLE;
          end else if (casFall) begin
            state_q <= ST_PRC_CAP;
            ramWe_q <= slotWe_q;
          end
        end
        ST_VID_CAP: begin
          videoData_q <= RAM_DIN;
          vidStb_q    <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_PRC_CAP: begin
          if (owner_q == OWN_DMA) begin
            if (!slotWe_q) begin
              dmaDout_q <= RAM_DIN;
            end
            dmaAck_q <= 1'b1;
          end else if (!slotWe_q) begin
            cpuDout_q <= RAM_DIN;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign RAM_ADDR   = ramAddr_q;
  assign RAM_WE     = ramWe_q;
  assign RAM_DOUT   = ramDout_q;
  assign VIDEO_DATA = videoData_q;
  assign VID_STB    = vidStb_q;
  assign CPU_DOUT   = cpuDout_q;
  assign CPU_RDY    = ~dmaGnt_q;
  assign DMA_GNT    = dmaGnt_q;
  assign DMA_ACK    = dmaAck_q;
  assign DMA_DOUT   = dmaDout_q;

endmodule

// File: tb/tb_memory_slot_arbiter.sv
// Directed bench for memory_slot_arbiter: drives PHI0/RAS/CAS slot patterns,
// models the RAM, and scores strobes and write pulses against queued values.
module tb_memory_slot_arbiter;
  import a2_mem_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wrExp_t;

  logic        CLK_14M;
  logic        RESET_N;
  logic        PHI0, RAS_N, CAS_N;
  logic [15:0] VIDEO_ADDRESS, CPU_ADDR, DMA_ADDR;
  logic        CPU_WE, DMA_REQ, DMA_WE;
  logic [7:0]  CPU_DIN, DMA_DIN;
  logic [15:0] RAM_ADDR;
  logic        RAM_WE;
  logic [7:0]  RAM_DOUT, RAM_DIN;
  logic [7:0]  VIDEO_DATA, CPU_DOUT, DMA_DOUT;
  logic        VID_STB, CPU_RDY, DMA_GNT, DMA_ACK;

  logic [7:0]  mem [0:65535];
  logic [7:0]  vidQ [$];
  logic [7:0]  ackQ [$];
  wrExp_t      weQ [$];

  int          checkCount;
  int          errorCount;
  logic        watchEn;
  logic        watchHit;
  logic [15:0] watchAddr;

  memory_slot_arbiter #(.DMA_ENABLE(1'b1)) dut (
    .CLK_14M       (CLK_14M),
    .RESET_N       (RESET_N),
    .PHI0          (PHI0),
    .RAS_N         (RAS_N),
    .CAS_N         (CAS_N),
    .VIDEO_ADDRESS (VIDEO_ADDRESS),
    .CPU_ADDR      (CPU_ADDR),
    .CPU_WE        (CPU_WE),
    .CPU_DIN       (CPU_DIN),
    .DMA_REQ       (DMA_REQ),
    .DMA_ADDR      (DMA_ADDR),
    .DMA_WE        (DMA_WE),
    .DMA_DIN       (DMA_DIN),
    .RAM_ADDR      (RAM_ADDR),
    .RAM_WE        (RAM_WE),
    .RAM_DOUT      (RAM_DOUT),
    .RAM_DIN       (RAM_DIN),
    .VIDEO_DATA    (VIDEO_DATA),
    .VID_STB       (VID_STB),
    .CPU_DOUT      (CPU_DOUT),
    .CPU_RDY       (CPU_RDY),
    .DMA_GNT       (DMA_GNT),
    .DMA_ACK       (DMA_ACK),
    .DMA_DOUT      (DMA_DOUT)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  // Single-port RAM with read data one cycle after the address.
  always @(posedge CLK_14M) begin
    if (RAM_WE) mem[RAM_ADDR] <= RAM_DOUT;
    RAM_DIN <= mem[RAM_ADDR];
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor pops the expected response whenever the DUT presents a strobe.
  always @(negedge CLK_14M) begin : monitor
    logic [7:0] e;
    wrExp_t     w;
    if (watchEn && RAM_ADDR == watchAddr) watchHit = 1'b1;
    if (VID_STB) begin
      if (vidQ.size() == 0) checkOutput("unexpected_vid_stb", 16'(VID_STB), 16'h0);
      else begin
        e = vidQ.pop_front();
        checkOutput("video_data", 16'(VIDEO_DATA), 16'(e));
      end
    end
    if (RAM_WE) begin
      if (weQ.size() == 0) checkOutput("unexpected_ram_we", 16'(RAM_WE), 16'h0);
      else begin
        w = weQ.pop_front();
        checkOutput("ram_we_addr", RAM_ADDR, w.addr);
        checkOutput("ram_we_data", 16'(RAM_DOUT), 16'(w.data));
      end
    end
    if (DMA_ACK) begin
      if (ackQ.size() == 0) checkOutput("unexpected_dma_ack", 16'(DMA_ACK), 16'h0);
      else begin
        e = ackQ.pop_front();
        checkOutput("dma_dout", 16'(DMA_DOUT), 16'(e));
      end
    end
  end

  task automatic applyStimulus(input logic p, input logic r, input logic c);
    @(negedge CLK_14M);
    PHI0  = p;
    RAS_N = r;
    CAS_N = c;
  endtask

  // Cycle k of a phase: RAS low from k=1, CAS low from k=3, both high on the last cycle.
  task automatic phaseCycle(input logic level, input int len, input int k);
    applyStimulus(level, (k >= 1 && k < len - 1) ? 1'b0 : 1'b1,
                  (k >= 3 && k < len - 1) ? 1'b0 : 1'b1);
  endtask

  task automatic runPhase(input logic level, input int len);
    for (int k = 0; k < len; k++) phaseCycle(level, len, k);
  endtask

  task automatic videoPhase(input logic [7:0] exp);
    vidQ.push_back(exp);
    runPhase(1'b0, 7);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ram_addr"},   RAM_ADDR,          16'h0);
    checkOutput({tag, "_ram_we"},     16'(RAM_WE),       16'h0);
    checkOutput({tag, "_ram_dout"},   16'(RAM_DOUT),     16'h0);
    checkOutput({tag, "_video_data"}, 16'(VIDEO_DATA),   16'h0);
    checkOutput({tag, "_vid_stb"},    16'(VID_STB),      16'h0);
    checkOutput({tag, "_cpu_dout"},   16'(CPU_DOUT),     16'h0);
    checkOutput({tag, "_dma_dout"},   16'(DMA_DOUT),     16'h0);
    checkOutput({tag, "_dma_gnt"},    16'(DMA_GNT),      16'h0);
    checkOutput({tag, "_dma_ack"},    16'(DMA_ACK),      16'h0);
    checkOutput({tag, "_cpu_rdy"},    16'(CPU_RDY),      16'h1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    checkCount = 0;
    errorCount = 0;
    watchEn = 1'b0;
    watchHit = 1'b0;
    watchAddr = 16'h0;
    RESET_N = 1'b0;
    PHI0 = 1'b0; RAS_N = 1'b1; CAS_N = 1'b1;
    VIDEO_ADDRESS = 16'h0400;
    CPU_ADDR = 16'h0100; CPU_WE = 1'b0; CPU_DIN = 8'h00;
    DMA_REQ = 1'b0; DMA_ADDR = 16'h0000; DMA_WE = 1'b0; DMA_DIN = 8'h00;
    mem[16'h0100] = 8'h11;
    mem[16'h0400] = 8'hA5;
    mem[16'h0800] = 8'h81;
    mem[16'h4000] = 8'h42;
    mem[16'hC0E0] = 8'h5A;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkResetValues("reset");
    RESET_N = 1'b1;

    // Video fetch on normal and long periods; CPU reads fill the high phases.
    repeat (3) begin videoPhase(8'hA5); runPhase(1'b1, 7); end
    checkOutput("cpu_dout_read", 16'(CPU_DOUT), 16'h11);
    repeat (2) begin videoPhase(8'hA5); runPhase(1'b1, 9); end
    VIDEO_ADDRESS = 16'h0800;
    videoPhase(8'h81);
    VIDEO_ADDRESS = 16'h0400;

    // CPU write; address/data changes after RAS fall must not leak into the slot.
    CPU_ADDR = 16'h2000; CPU_WE = 1'b1; CPU_DIN = 8'h3C;
    weQ.push_back('{16'h2000, 8'h3C});
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b1, 7, k);
      if (k == 2) begin CPU_ADDR = 16'h2100; CPU_DIN = 8'hFF; end
    end
    checkOutput("cpu_dout_after_write", 16'(CPU_DOUT), 16'h11);
    CPU_ADDR = 16'h2000; CPU_WE = 1'b0; CPU_DIN = 8'h00;
    videoPhase(8'hA5);
    runPhase(1'b1, 7);
    checkOutput("cpu_dout_readback", 16'(CPU_DOUT), 16'h3C);

    // DMA takeover: request raised during the low phase, dropped mid-slot.
    DMA_REQ = 1'b1; DMA_ADDR = 16'hC0E0; DMA_WE = 1'b0;
    vidQ.push_back(8'hA5);
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b0, 7, k);
      if (k == 3) checkOutput("gnt_before_rise", 16'(DMA_GNT), 16'h0);
    end
    ackQ.push_back(8'h5A);
    watchAddr = CPU_ADDR;
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b1, 7, k);
      if (k == 0) begin watchHit = 1'b0; watchEn = 1'b1; end
      if (k == 2) begin
        checkOutput("dma_ram_addr", RAM_ADDR, 16'hC0E0);
        checkOutput("dma_gnt_on", 16'(DMA_GNT), 16'h1);
        checkOutput("cpu_rdy_off", 16'(CPU_RDY), 16'h0);
      end
      if (k == 3) DMA_REQ = 1'b0;
      if (k == 6) checkOutput("gnt_hold_slot", 16'(DMA_GNT), 16'h1);
    end
    watchEn = 1'b0;
    checkOutput("cpu_addr_in_dma_slot", 16'(watchHit), 16'h0);
    checkOutput("cpu_dout_untouched", 16'(CPU_DOUT), 16'h3C);
    vidQ.push_back(8'hA5);
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b0, 7, k);
      if (k == 3) checkOutput("gnt_hold_low", 16'(DMA_GNT), 16'h1);
    end
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b1, 7, k);
      if (k == 2) begin
        checkOutput("gnt_released", 16'(DMA_GNT), 16'h0);
        checkOutput("cpu_rdy_back", 16'(CPU_RDY), 16'h1);
      end
    end

    // DMA write with the request raised on the PHI0-rise cycle itself.
    videoPhase(8'hA5);
    DMA_ADDR = 16'hC0E1; DMA_WE = 1'b1; DMA_DIN = 8'h77;
    weQ.push_back('{16'hC0E1, 8'h77});
    ackQ.push_back(8'h5A);
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b1, 7, k);
      if (k == 0) DMA_REQ = 1'b1;
      if (k == 2) checkOutput("gnt_same_cycle", 16'(DMA_GNT), 16'h1);
    end
    DMA_REQ = 1'b0; DMA_WE = 1'b0;
    videoPhase(8'hA5);
    CPU_ADDR = 16'hC0E1;
    runPhase(1'b1, 7);
    checkOutput("dma_write_readback", 16'(CPU_DOUT), 16'h77);

    // Video abort: PHI0 rises between RAS fall and CAS fall.
    for (int k = 0; k < 7; k++) begin
      applyStimulus((k >= 2) ? 1'b1 : 1'b0, (k >= 1 && k < 6) ? 1'b0 : 1'b1,
                    (k >= 3 && k < 6) ? 1'b0 : 1'b1);
      if (k == 5) checkOutput("abort_vid_idle", 16'(dut.state_q), 16'(ST_IDLE));
    end
    runPhase(1'b1, 7);
    checkOutput("abort_vid_data", 16'(VIDEO_DATA), 16'hA5);

    // Processor abort: PHI0 falls before CAS on a CPU write slot.
    CPU_ADDR = 16'h4000; CPU_WE = 1'b1; CPU_DIN = 8'h99;
    for (int k = 0; k < 7; k++) begin
      applyStimulus((k >= 2) ? 1'b0 : 1'b1, (k >= 1 && k < 6) ? 1'b0 : 1'b1,
                    (k >= 3 && k < 6) ? 1'b0 : 1'b1);
      if (k == 5) checkOutput("abort_prc_idle", 16'(dut.state_q), 16'(ST_IDLE));
    end
    CPU_WE = 1'b0; CPU_DIN = 8'h00;
    videoPhase(8'hA5);
    runPhase(1'b1, 7);
    checkOutput("abort_no_write", 16'(CPU_DOUT), 16'h42);

    // Reset asserted on the RAM_WE cycle of a CPU write.
    videoPhase(8'hA5);
    CPU_ADDR = 16'h3000; CPU_WE = 1'b1; CPU_DIN = 8'hEE;
    weQ.push_back('{16'h3000, 8'hEE});
    for (int k = 0; k < 7; k++) begin
      phaseCycle(1'b1, 7, k);
      if (k == 4) RESET_N = 1'b0;
      if (k == 5) checkResetValues("midreset");
    end
    CPU_WE = 1'b0; CPU_DIN = 8'h00; CPU_ADDR = 16'h0100;
    RESET_N = 1'b1;
    videoPhase(8'hA5);
    runPhase(1'b1, 7);
    checkOutput("post_reset_video", 16'(VIDEO_DATA), 16'hA5);

    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("vid_queue_drained", 16'(vidQ.size()), 16'h0);
    checkOutput("we_queue_drained",  16'(weQ.size()),  16'h0);
    checkOutput("ack_queue_drained", 16'(ackQ.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
